// File: rtl/mexecute_mem_unit.sv
// mexecute_mem_unit: execute/memory stage for vector element accesses.
// Purpose: accepts one decoded op while idle. A non-memory op passes through
//   to writeback in one cycle. A memory op issues lane+1 strided element
//   requests, one at a time, each completed by dmem_ack, and streams load data
//   back to writeback.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   pc, dir_mem, dato_vectA,
//   lane, mux_key                decode fields (sampled only while idle)
//   escritura_regV, lectura_dmem,
//   escritura_dmem, select_wb    decode control bits
//   busy                         stall request upstream (high while issuing)
//   dmem_*                       data-memory request/response port
//   wb_*                         writeback stream (wb_valid qualifies it)
//   err                          one-cycle pulse for an op with both read and write set
module mexecute_mem_unit #(
  parameter int unsigned DATA_W = 23,
  parameter int unsigned ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       pc,
  input  logic [ADDR_W-1:0] dir_mem,
  input  logic [DATA_W-1:0] dato_vectA,
  input  logic [4:0]        lane,
  input  logic [1:0]        mux_key,
  input  logic              escritura_regV,
  input  logic              lectura_dmem,
  input  logic              escritura_dmem,
  input  logic              select_wb,
  output logic              busy,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_rd,
  output logic              dmem_wr,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_lane,
  output logic              wb_select,
  output logic [15:0]       wb_pc,
  output logic              err
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [0:0]  r_state;
  logic [4:0]  r_i;
  logic [4:0]  r_last;
  logic [2:0]  r_stride;
  logic        r_sel;
  logic [15:0] r_pc;

  logic [0:0]        w_state_nxt;
  logic [4:0]        w_i_nxt;
  logic [4:0]        w_last_nxt;
  logic [2:0]        w_stride_nxt;
  logic              w_sel_nxt;
  logic [15:0]       w_pc_nxt;
  logic              w_busy_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_wdata_nxt;
  logic              w_rd_nxt;
  logic              w_wr_nxt;
  logic              w_wb_valid_nxt;
  logic [DATA_W-1:0] w_wb_data_nxt;
  logic [4:0]        w_wb_lane_nxt;
  logic              w_wb_sel_nxt;
  logic [15:0]       w_wb_pc_nxt;
  logic              w_err_nxt;

  logic              w_mem_op;
  logic [2:0]        w_stride;

  assign w_mem_op = lectura_dmem | escritura_dmem;

  // Address step per element selected by mux_key; 11 repeats the same address.
  always_comb begin
    w_stride = 3'd0;
    case (mux_key)
      2'b00:   w_stride = 3'd1;
      2'b01:   w_stride = 3'd2;
      2'b10:   w_stride = 3'd4;
      default: w_stride = 3'd0;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_i_nxt        = r_i;
    w_last_nxt     = r_last;
    w_stride_nxt   = r_stride;
    w_sel_nxt      = r_sel;
    w_pc_nxt       = r_pc;
    w_busy_nxt     = busy;
    w_addr_nxt     = dmem_addr;
    w_wdata_nxt    = dmem_wdata;
    w_rd_nxt       = dmem_rd;
    w_wr_nxt       = dmem_wr;
    w_wb_valid_nxt = 1'b0;
    w_wb_data_nxt  = wb_data;
    w_wb_lane_nxt  = wb_lane;
    w_wb_sel_nxt   = wb_select;
    w_wb_pc_nxt    = wb_pc;
    w_err_nxt      = 1'b0;

    if (r_state == IDLE) begin
      if (w_mem_op) begin
        // Read+write together is illegal: flag it and run it as a load.
        w_state_nxt  = ISSUE;
        w_i_nxt      = 5'd0;
        w_last_nxt   = lane;
        w_stride_nxt = w_stride;
        w_sel_nxt    = select_wb;
        w_pc_nxt     = pc;
        w_busy_nxt   = 1'b1;
        w_addr_nxt   = dir_mem;
        w_wdata_nxt  = dato_vectA;
        w_rd_nxt     = lectura_dmem;
        w_wr_nxt     = ~lectura_dmem;
        w_err_nxt    = lectura_dmem & escritura_dmem;
      end else begin
        w_wb_valid_nxt = escritura_regV;
        w_wb_data_nxt  = dato_vectA;
        w_wb_lane_nxt  = lane;
        w_wb_sel_nxt   = select_wb;
        w_wb_pc_nxt    = pc;
      end
    end else if (dmem_ack) begin
      if (dmem_rd) begin
        w_wb_valid_nxt = 1'b1;
        w_wb_data_nxt  = dmem_rdata;
        w_wb_lane_nxt  = r_i;
        w_wb_sel_nxt   = r_sel;
        w_wb_pc_nxt    = r_pc;
      end
      if (r_i == r_last) begin
        w_state_nxt = IDLE;
        w_i_nxt     = 5'd0;
        w_busy_nxt  = 1'b0;
        w_rd_nxt    = 1'b0;
        w_wr_nxt    = 1'b0;
      end else begin
        // Next element address; wraps modulo 2^ADDR_W.
        w_i_nxt    = r_i + 5'd1;
        w_addr_nxt = dmem_addr + ADDR_W'(r_stride);
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_i        <= 5'd0;
      r_last     <= 5'd0;
      r_stride   <= 3'd0;
      r_sel      <= 1'b0;
      r_pc       <= 16'd0;
      busy       <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_rd    <= 1'b0;
      dmem_wr    <= 1'b0;
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_lane    <= 5'd0;
      wb_select  <= 1'b0;
      wb_pc      <= 16'd0;
      err        <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_i        <= w_i_nxt;
      r_last     <= w_last_nxt;
      r_stride   <= w_stride_nxt;
      r_sel      <= w_sel_nxt;
      r_pc       <= w_pc_nxt;
      busy       <= w_busy_nxt;
      dmem_addr  <= w_addr_nxt;
      dmem_wdata <= w_wdata_nxt;
      dmem_rd    <= w_rd_nxt;
      dmem_wr    <= w_wr_nxt;
      wb_valid   <= w_wb_valid_nxt;
      wb_data    <= w_wb_data_nxt;
      wb_lane    <= w_wb_lane_nxt;
      wb_select  <= w_wb_sel_nxt;
      wb_pc      <= w_wb_pc_nxt;
      err        <= w_err_nxt;
    end
  end

endmodule
